vx_mem_req_rr_arb: RTL



---
 rtl/vx_mem_req_rr_arb.sv | 136 +++++++++++++
 1 files changed

// File: rtl/vx_mem_req_rr_arb.sv
// Round-robin arbiter sharing one registered memory request channel between
// NUM_REQS requesters; the winner index is appended to the tag LSBs for response routing.
module vx_mem_req_rr_arb #(
    parameter int NUM_REQS     = 4,
    parameter int DATA_WIDTH   = 512,
    parameter int ADDR_WIDTH   = 26,
    parameter int TAG_IN_WIDTH = 8,
    parameter int DATA_SIZE    = DATA_WIDTH / 8,
    localparam int SIZE_WIDTH    = $clog2($clog2(DATA_SIZE) + 1),
    localparam int LOG_REQS      = $clog2(NUM_REQS),
    localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_REQS
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQS-1:0]              req_valid,
    input  logic [NUM_REQS-1:0]              req_rw,
    input  logic [NUM_REQS*DATA_SIZE-1:0]    req_byteen,
    input  logic [NUM_REQS*SIZE_WIDTH-1:0]   req_size,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQS*DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQS*TAG_IN_WIDTH-1:0] req_tag,
    output logic [NUM_REQS-1:0]              req_ready,
    output logic                             mem_req_valid,
    output logic                             mem_req_rw,
    output logic [DATA_SIZE-1:0]             mem_req_byteen,
    output logic [SIZE_WIDTH-1:0]            mem_req_size,
    output logic [ADDR_WIDTH-1:0]            mem_req_addr,
    output logic [DATA_WIDTH-1:0]            mem_req_data,
    output logic [TAG_OUT_WIDTH-1:0]         mem_req_tag,
    input  logic                             mem_req_ready
);

    localparam int PTR_EXT_W = LOG_REQS + 1;

    logic [LOG_REQS-1:0]      rr_ptr_q, rr_ptr_d;
    logic                     out_valid_q, out_valid_d;
    logic                     rw_q;
    logic [DATA_SIZE-1:0]     byteen_q;
    logic [SIZE_WIDTH-1:0]    size_q;
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [DATA_WIDTH-1:0]    data_q;
    logic [TAG_OUT_WIDTH-1:0] tag_q;

    logic [PTR_EXT_W-1:0]     scan_s;
    logic [LOG_REQS-1:0]      grant_idx_s;
    logic                     any_valid_s;
    logic                     can_load_s;
    logic                     load_s;

    // Grant search: first valid requester at or after rr_ptr, wrapping at NUM_REQS
    always_comb begin
        grant_idx_s = '0;
        any_valid_s = 1'b0;
        scan_s      = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            scan_s = {1'b0, rr_ptr_q} + PTR_EXT_W'(k);
            if (scan_s >= PTR_EXT_W'(NUM_REQS)) begin
                scan_s = scan_s - PTR_EXT_W'(NUM_REQS);
            end else begin
                scan_s = scan_s;
            end
            if (!any_valid_s && req_valid[scan_s[LOG_REQS-1:0]]) begin
                any_valid_s = 1'b1;
                grant_idx_s = scan_s[LOG_REQS-1:0];
            end else begin
                any_valid_s = any_valid_s;
            end
        end
    end

    // reset gates acceptance so nothing handshakes while the block is held in reset
    assign can_load_s = !out_valid_q || mem_req_ready;
    assign load_s     = can_load_s && any_valid_s && reset;

    // Next-state for pointer and output-valid
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        if (load_s) begin
            out_valid_d = 1'b1;
            if (grant_idx_s == LOG_REQS'(NUM_REQS - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx_s + LOG_REQS'(1);
            end
        end else if (mem_req_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Acceptance strobe to the winning requester
    always_comb begin
        req_ready = '0;
        if (load_s) begin
            req_ready[grant_idx_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Pointer, valid and payload registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            rw_q        <= 1'b0;
            byteen_q    <= '0;
            size_q      <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            tag_q       <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            if (load_s) begin
                rw_q     <= req_rw[grant_idx_s];
                byteen_q <= req_byteen[int'(grant_idx_s)*DATA_SIZE +: DATA_SIZE];
                size_q   <= req_size[int'(grant_idx_s)*SIZE_WIDTH +: SIZE_WIDTH];
                addr_q   <= req_addr[int'(grant_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
                data_q   <= req_data[int'(grant_idx_s)*DATA_WIDTH +: DATA_WIDTH];
                tag_q    <= {req_tag[int'(grant_idx_s)*TAG_IN_WIDTH +: TAG_IN_WIDTH], grant_idx_s};
            end
        end
    end

    assign mem_req_valid  = out_valid_q;
    assign mem_req_rw     = rw_q;
    assign mem_req_byteen = byteen_q;
    assign mem_req_size   = size_q;
    assign mem_req_addr   = addr_q;
    assign mem_req_data   = data_q;
    assign mem_req_tag    = tag_q;

endmodule
